// File: rtl/rca_seq_adder.sv
// Multi-cycle ripple-carry adder/subtractor: one CHUNK-bit slice per clock,
// carry registered between slices, valid/ready handshake on both sides.
module rca_seq_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
  input  logic             in,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [KW-1:0]    k_r;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] s_r;
  logic             c_r;
  logic             v_r;
  logic             in_ready_s;
  logic             out_valid_s;
  logic             last_slice_s;
  int               base_s;
  logic [CHUNK:0]   slice_sum_s;
  logic [WIDTH-1:0] sum_full_s;
  logic             v_s;

  assign S         = s_r;
  assign C         = c_r;
  assign V         = v_r;
  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  assign last_slice_s = (state_r == ST_CALC) && (k_r == K_LAST);

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) state_nxt_s = ST_CALC;
        else          state_nxt_s = ST_IDLE;
      end
      ST_CALC: begin
        if (last_slice_s) state_nxt_s = ST_DONE;
        else              state_nxt_s = ST_CALC;
      end
      ST_DONE: begin
        if (out_ready) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    case (state_r)
      ST_IDLE: in_ready_s  = rst_n;
      ST_DONE: out_valid_s = 1'b1;
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Current slice sum and the full word it completes (sum_r never leaves the block)
  always_comb begin
    base_s      = int'(k_r) * CHUNK;
    slice_sum_s = {1'b0, a_r[base_s +: CHUNK]} + {1'b0, b_r[base_s +: CHUNK]}
                + {{CHUNK{1'b0}}, carry_r};
    sum_full_s  = sum_r;
    sum_full_s[base_s +: CHUNK] = slice_sum_s[CHUNK-1:0];
    v_s = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_full_s[WIDTH-1] != a_r[WIDTH-1]);
  end

  // Operand capture, slice iteration and result load on the final slice
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      k_r     <= {KW{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      s_r     <= {WIDTH{1'b0}};
      c_r     <= 1'b0;
      v_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_r     <= A1;
            b_r     <= mode ? ~A2 : A2;
            carry_r <= in ^ mode;
            k_r     <= {KW{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
          end else begin
            k_r     <= k_r;
          end
        end
        ST_CALC: begin
          sum_r   <= sum_full_s;
          carry_r <= slice_sum_s[CHUNK];
          k_r     <= k_r + {{(KW-1){1'b0}}, 1'b1};
          if (last_slice_s) begin
            s_r <= sum_full_s;
            c_r <= slice_sum_s[CHUNK];
            v_r <= v_s;
          end else begin
            s_r <= s_r;
          end
        end
        default: begin
          s_r <= s_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_seq_adder.sv
// Directed bench: a 32/8 instance and a 16/4 instance share stimulus
// (the narrow one sees the low half of each operand); both take 4 slices.
module tb_rca_seq_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a1, a2;
  logic        cin, mode, in_valid, out_ready;

  logic        rdy0, c0, v0, ov0;
  logic [31:0] s0;
  logic        rdy1, c1, v1, ov1;
  logic [15:0] s1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rca_seq_adder #(.WIDTH(32), .CHUNK(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .A1(a1), .A2(a2), .in(cin), .mode(mode),
    .in_valid(in_valid), .in_ready(rdy0), .S(s0), .C(c0), .V(v0),
    .out_valid(ov0), .out_ready(out_ready)
  );

  rca_seq_adder #(.WIDTH(16), .CHUNK(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .A1(a1[15:0]), .A2(a2[15:0]), .in(cin), .mode(mode),
    .in_valid(in_valid), .in_ready(rdy1), .S(s1), .C(c1), .V(v1),
    .out_valid(ov1), .out_ready(out_ready)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation: accept, check latency and result on both widths, then handoff.
  task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic ci, input logic md, input logic hold,
                       input logic [31:0] es, input logic ec, input logic ev,
                       input logic [15:0] es16, input logic ec16, input logic ev16);
    check_eq({tag, ".rdy"}, {rdy0, rdy1}, 2'b11);
    a1 = x; a2 = y; cin = ci; mode = md; in_valid = 1'b1; out_ready = hold;
    tick();
    in_valid = 1'b0; a1 = $urandom; a2 = $urandom; cin = ~ci; mode = ~md;
    check_eq({tag, ".busy"}, rdy0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick();
      check_eq({tag, ".early"}, {ov0, ov1}, 2'b00);
    end
    tick();
    check_eq({tag, ".ov"},  {ov0, ov1}, 2'b11);
    check_eq({tag, ".S"},   s0, es);
    check_eq({tag, ".CV"},  {c0, v0}, {ec, ev});
    check_eq({tag, ".S16"}, s1, es16);
    check_eq({tag, ".CV16"}, {c1, v1}, {ec16, ev16});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, ".idle"}, {rdy0, ov0}, 2'b10);
    check_eq({tag, ".keepS"}, s0, es);
  endtask

  initial begin
    rst_n = 1'b0; a1 = 32'h0; a2 = 32'h0; cin = 1'b0; mode = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check_eq("rst.rdy", {rdy0, rdy1}, 2'b00);
    check_eq("rst.out", {s0, c0, v0, ov0}, 35'h0);
    rst_n = 1'b1;
    tick();

    //      tag      A1            A2            in    mode  hold  S             C     V     S16       C16   V16
    do_op("add1",  32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h00000001, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0);
    do_op("ripple",32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("ovf",   32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    do_op("sub57", 32'h00000005, 32'h00000007, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub75", 32'h00000007, 32'h00000005, 1'b1, 1'b1, 1'b1, 32'h00000001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
    do_op("subov", 32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    do_op("slice", 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h00000100, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    do_op("ovf16", 32'h00007FFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00008000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

    // Backpressure: hold the result while in_valid and A1 wiggle
    a1 = 32'h0000FFFF; a2 = 32'h00000001; cin = 1'b0; mode = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid; a1 = $urandom;
      tick();
      check_eq("bp.ov",  {ov0, rdy0}, 2'b10);
      check_eq("bp.S",   {s0, c0, v0}, {32'h00010000, 1'b0, 1'b0});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("bp.idle", {rdy0, ov0}, 2'b10);
    repeat (6) tick();
    check_eq("bp.noop", {ov0, rdy0, s0}, {1'b0, 1'b1, 32'h00010000});

    // Reset in the middle of a calculation discards it
    a1 = 32'hAAAAAAAA; a2 = 32'h55555555; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check_eq("mid.out",   {s0, c0, v0, ov0}, 35'h0);
    check_eq("mid.out16", {s1, c1, v1, ov1}, 19'h0);
    check_eq("mid.rdy",   rdy0, 1'b0);
    rst_n = 1'b1;
    tick();
    check_eq("mid.rel", {rdy0, ov0}, 2'b10);
    do_op("fresh", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 16'h6789, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
